// File: rtl/mul_div_unit_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
// The master side is the EX/hazard logic; the slave side is the MDU itself.
interface mul_div_unit_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        md_cancel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_use_D;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        stall_req;

    modport master (
        output md_valid, md_op, md_cancel, rs_data, rt_data, md_use_D,
        input  hi_out, lo_out, busy, stall_req
    );

    modport slave (
        input  md_valid, md_op, md_cancel, rs_data, rt_data, md_use_D,
        output hi_out, lo_out, busy, stall_req
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU, MTHI/MTLO, and the
// architectural HI/LO registers. Results are computed at issue and held until the latency expires.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_unit_if.slave md
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_reg, lo_reg;
    logic [31:0]      temp_hi, temp_lo;
    logic             div0_q;

    logic        accept, start, is_div, is_signed, mt_hi, mt_lo, commit;
    logic [63:0] result;

    function automatic logic [63:0] mul_result(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        return sgn ? sp : up;
    endfunction

    // Returns {remainder, quotient}; the INT_MIN / -1 overflow is pinned explicitly
    // so the result does not depend on the host division semantics.
    function automatic logic [63:0] div_result(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [63:0]        res;
        sa  = a;
        sb  = b;
        sq  = '0;
        sr  = '0;
        res = '0;
        if (b != 32'd0) begin
            if (sgn) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr, sq};
                end
            end else begin
                res = {a % b, a / b};
            end
        end
        return res;
    endfunction

    assign accept    = md.md_valid && !md.md_cancel && (state_q == IDLE);
    assign is_div    = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
    assign is_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
    assign start     = accept && (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    assign mt_hi     = accept && (md.md_op == OP_MTHI);
    assign mt_lo     = accept && (md.md_op == OP_MTLO);
    assign result    = is_div ? div_result(is_signed, md.rs_data, md.rt_data)
                              : mul_result(is_signed, md.rs_data, md.rt_data);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
            div0_q  <= 1'b0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                temp_hi <= result[63:32];
                temp_lo <= result[31:0];
                div0_q  <= is_div && (md.rt_data == 32'd0);
            end
            if (commit && !div0_q) begin
                hi_reg <= temp_hi;
                lo_reg <= temp_lo;
            end
            if (mt_hi) hi_reg <= md.rs_data;
            if (mt_lo) lo_reg <= md.rs_data;
        end
    end

    assign md.hi_out    = hi_reg;
    assign md.lo_out    = lo_reg;
    assign md.busy      = (state_q == RUN);
    assign md.stall_req = md.md_use_D && (md.busy || start);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results, cancel, busy-ignore,
// stall_req and mid-operation reset.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_div_unit_if mif ();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.md_valid  = 1'b0;
        mif.md_op     = 3'd0;
        mif.md_cancel = 1'b0;
        mif.rs_data   = 32'h0;
        mif.rt_data   = 32'h0;
        mif.md_use_D  = 1'b0;
    endtask

    // Present one request for a single edge, then return to idle inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic cancel);
        mif.md_valid  = 1'b1;
        mif.md_op     = op;
        mif.rs_data   = rs;
        mif.rt_data   = rt;
        mif.md_cancel = cancel;
        step();
        idle_inputs();
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (mif.busy && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (mif.hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", mif.hi_out, 32'h0); end
        n_cmp++; if (mif.lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", mif.lo_out, 32'h0); end
        n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    endtask

    task automatic test_mthi();
        issue(3'd5, 32'h1234_5678, 32'h0, 1'b0);
        n_cmp++; if (mif.hi_out !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_hi: got %h want %h", mif.hi_out, 32'h1234_5678); end
        n_cmp++; if (mif.lo_out !== 32'h0) begin n_bad++; $display("FAIL mthi_lo: got %h want %h", mif.lo_out, 32'h0); end
        n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", mif.busy); end
    endtask

    task automatic test_mult();
        int cyc;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        n_cmp++; if (mif.hi_out !== 32'h1234_5678) begin n_bad++; $display("FAIL mult_hold_hi: got %h want %h", mif.hi_out, 32'h1234_5678); end
        count_busy(cyc);
        n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL mult_latency: got %0d want 5", cyc); end
        n_cmp++; if (mif.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want %h", mif.hi_out, 32'hFFFF_FFFF); end
        n_cmp++; if (mif.lo_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo: got %h want %h", mif.lo_out, 32'hFFFF_FFFE); end
        // Issued in the first idle cycle: back-to-back spacing.
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        count_busy(cyc);
        n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL multu_latency: got %0d want 5", cyc); end
        n_cmp++; if (mif.hi_out !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_hi: got %h want %h", mif.hi_out, 32'h1); end
        n_cmp++; if (mif.lo_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want %h", mif.lo_out, 32'hFFFF_FFFE); end
    endtask

    task automatic test_div();
        int cyc;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        count_busy(cyc);
        n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL div_latency: got %0d want 10", cyc); end
        n_cmp++; if (mif.lo_out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo: got %h want %h", mif.lo_out, 32'hFFFF_FFFD); end
        n_cmp++; if (mif.hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi: got %h want %h", mif.hi_out, 32'hFFFF_FFFF); end
        issue(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        count_busy(cyc);
        n_cmp++; if (mif.lo_out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_negdivisor_lo: got %h want %h", mif.lo_out, 32'hFFFF_FFFD); end
        n_cmp++; if (mif.hi_out !== 32'h0000_0001) begin n_bad++; $display("FAIL div_negdivisor_hi: got %h want %h", mif.hi_out, 32'h1); end
        issue(3'd4, 32'd7, 32'd2, 1'b0);
        count_busy(cyc);
        n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divu_latency: got %0d want 10", cyc); end
        n_cmp++; if (mif.lo_out !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want %h", mif.lo_out, 32'd3); end
        n_cmp++; if (mif.hi_out !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want %h", mif.hi_out, 32'd1); end
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        count_busy(cyc);
        n_cmp++; if (mif.lo_out !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo: got %h want %h", mif.lo_out, 32'h8000_0000); end
        n_cmp++; if (mif.hi_out !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi: got %h want %h", mif.hi_out, 32'h0); end
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(3'd6, 32'hAAAA_5555, 32'h0, 1'b0);
        issue(3'd5, 32'h0BAD_F00D, 32'h0, 1'b0);
        issue(3'd4, 32'd5, 32'd0, 1'b0);
        count_busy(cyc);
        n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divzero_latency: got %0d want 10", cyc); end
        n_cmp++; if (mif.lo_out !== 32'hAAAA_5555) begin n_bad++; $display("FAIL divzero_lo: got %h want %h", mif.lo_out, 32'hAAAA_5555); end
        n_cmp++; if (mif.hi_out !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL divzero_hi: got %h want %h", mif.hi_out, 32'h0BAD_F00D); end
    endtask

    task automatic test_cancel();
        issue(3'd1, 32'd3, 32'd4, 1'b1);
        n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy: got %b want 0", mif.busy); end
        for (int i = 0; i < 7; i++) step();
        n_cmp++; if (mif.lo_out !== 32'hAAAA_5555) begin n_bad++; $display("FAIL cancel_lo: got %h want %h", mif.lo_out, 32'hAAAA_5555); end
        n_cmp++; if (mif.hi_out !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL cancel_hi: got %h want %h", mif.hi_out, 32'h0BAD_F00D); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        issue(3'd1, 32'd100, 32'd100, 1'b0);
        issue(3'd6, 32'h0000_DEAD, 32'h0, 1'b0);
        count_busy(cyc);
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL ignore_remaining_busy: got %0d want 3", cyc); end
        n_cmp++; if (mif.lo_out !== 32'd12) begin n_bad++; $display("FAIL ignore_lo: got %h want %h", mif.lo_out, 32'd12); end
        n_cmp++; if (mif.hi_out !== 32'd0) begin n_bad++; $display("FAIL ignore_hi: got %h want %h", mif.hi_out, 32'd0); end
    endtask

    task automatic test_stall();
        mif.md_use_D = 1'b1;
        step();
        n_cmp++; if (mif.stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got %b want 0", mif.stall_req); end
        mif.md_valid = 1'b1;
        mif.md_op    = 3'd1;
        mif.rs_data  = 32'd2;
        mif.rt_data  = 32'd3;
        #1;
        n_cmp++; if (mif.stall_req !== 1'b1) begin n_bad++; $display("FAIL stall_start: got %b want 1", mif.stall_req); end
        step();
        mif.md_valid = 1'b0;
        mif.md_op    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (mif.stall_req !== 1'b1) begin n_bad++; $display("FAIL stall_busy_cycle%0d: got %b want 1", i, mif.stall_req); end
            step();
        end
        n_cmp++; if (mif.stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_after: got %b want 0", mif.stall_req); end
        n_cmp++; if (mif.lo_out !== 32'd6) begin n_bad++; $display("FAIL stall_mult_lo: got %h want %h", mif.lo_out, 32'd6); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        issue(3'd5, 32'h0000_0055, 32'h0, 1'b0);
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        step();
        step();
        n_cmp++; if (mif.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", mif.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", mif.busy); end
        n_cmp++; if (mif.hi_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi: got %h want %h", mif.hi_out, 32'h0); end
        n_cmp++; if (mif.lo_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo: got %h want %h", mif.lo_out, 32'h0); end
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (mif.hi_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_late_hi: got %h want %h", mif.hi_out, 32'h0); end
        n_cmp++; if (mif.lo_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_late_lo: got %h want %h", mif.lo_out, 32'h0); end
        n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_busy: got %b want 0", mif.busy); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mthi();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_busy_ignore();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multiply/divide unit of the EX stage: executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, services MTHI/MTLO, and holds the architectural HI/LO registers. It sits directly upstream of the EX/MEM pipeline register: its `hi_out`/`lo_out` feed that register's HI/LO inputs. Its `busy` and `stall_req` feed the hazard unit, which freezes decode while an HI/LO consumer would otherwise read stale data.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- md_valid  in  1  EX holds an MDU-issuing instruction this cycle
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- md_cancel  in  1  EX instruction is being flushed (exception/interrupt); suppresses acceptance
- rs_data  in  32  forwarded GPR[rs] (dividend / multiplicand / MT source)
- rt_data  in  32  forwarded GPR[rt] (divisor / multiplier)
- md_use_D  in  1  instruction in decode uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- busy  out  1  long operation in flight
- stall_req  out  1  md_use_D && (busy || start), combinational

## Operation
- accept = md_valid && !md_cancel && !busy. Start is asserted when accept holds and md_op ∈ {1..4}.
- On an accepted MULT/MULTU/DIV/DIVU edge:
  - compute the 64-bit result from the sampled rs_data/rt_data into temp_hi/temp_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - hi_out/lo_out are unchanged.
- MULT: {hi,lo} = signed rs × signed rt. MULTU: unsigned 64-bit product.
- DIV:
  - lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (rt_data=0): busy still runs DIV_CYCLES; HI/LO are not written at completion.
- Accepted MTHI writes hi_out <= rs_data; accepted MTLO writes lo_out <= rs_data, both at that edge. busy is not asserted.
- Requests while busy (any md_op) are ignored. The hazard unit is required never to issue them; the unit does not queue them.
- md_cancel does not abort an operation already in flight. It only blocks acceptance in the same cycle.
- States: IDLE (counter=0) → RUN on start; in RUN the counter decrements each edge. At the edge where the counter goes 1→0, commit temp_hi/temp_lo to hi_out/lo_out (unless the operation was divide-by-zero) and return to IDLE.

## Timing
- Reset values: hi_out=0, lo_out=0, busy=0, counter=0, temp regs=0, div-by-zero flag=0. Reset mid-operation abandons it with no HI/LO commit.
- Start accepted at edge E0 → busy=1 for cycles after E0 through edge E_N (N = MULT_CYCLES or DIV_CYCLES), i.e. exactly N cycles.
- At edge E_N, HI/LO are updated and busy falls. An mfhi/mflo reading in the cycle after E_N sees the new values.
- A new start is acceptable in the first cycle with busy=0. Back-to-back operations are therefore spaced N+1 edges apart.
- MTHI/MTLO: 1-edge latency; the new value is visible in the next cycle.
- stall_req is high in the start cycle itself (busy still 0), so a decode-stage mfhi is held from the start cycle through the last busy cycle.
- busy, hi_out and lo_out are registered; stall_req is the only combinational output.

## Test plan
- After reset: hi_out=0, lo_out=0, busy=0. MTHI with rs=0x12345678 → next cycle hi_out=0x12345678, busy stays 0.
- MULT, rs=0xFFFFFFFF, rt=2 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV, rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, rs=7, rt=2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU with rt=0 after MTLO 0xAAAA5555 → busy still 10 cycles; lo stays 0xAAAA5555.
- MULT issued with md_cancel=1 → busy stays 0, HI/LO unchanged. MULT issued while busy → ignored, the original result commits unchanged. md_use_D=1 in the start cycle and all busy cycles → stall_req=1 in each of them, 0 afterwards.
- Reset asserted in the 3rd busy cycle of DIV → next cycle busy=0, hi=lo=0, and no later commit.
